// File: rtl/tu_stream_scheduler_if.sv
// Handshake bundle between the line/FIFO control side and the TU stream scheduler.
// master drives config, line_start and FIFO status; slave is the scheduler.
interface tu_stream_scheduler_if #(
  parameter int CNT_W  = 7,
  parameter int LINE_W = 16
);
  logic              cfg_en;
  logic [CNT_W-1:0]  cfg_vld_symbols;
  logic [LINE_W-1:0] cfg_line_symbols;
  logic              line_start;
  logic              fifo_empty;
  logic              sched_rd_en;
  logic              sched_stream_en;
  logic [1:0]        sched_stream_state;
  logic              sched_line_done;
  logic              sched_underflow;
  logic              sched_overrun;

  modport master (
    output cfg_en, cfg_vld_symbols, cfg_line_symbols, line_start, fifo_empty,
    input  sched_rd_en, sched_stream_en, sched_stream_state, sched_line_done,
           sched_underflow, sched_overrun
  );

  modport slave (
    input  cfg_en, cfg_vld_symbols, cfg_line_symbols, line_start, fifo_empty,
    output sched_rd_en, sched_stream_en, sched_stream_state, sched_line_done,
           sched_underflow, sched_overrun
  );
endinterface

// File: rtl/tu_stream_scheduler.sv
// Frames one lane's active line into TU_SIZE-slot transfer units and tells the
// mapper per slot whether to send data, FS, stuffing or FE; pops the FIFO on data slots.
module tu_stream_scheduler #(
  parameter int TU_SIZE = 64,
  parameter int CNT_W   = $clog2(TU_SIZE) + 1,
  parameter int LINE_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  tu_stream_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] TU_C = CNT_W'(TU_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TU_SIZE - 1);

  typedef enum logic [2:0] {IDLE, DATA, FS, STUFF, FE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  slot, slot_nxt;
  logic [CNT_W-1:0]  v_s, v_s_nxt;
  logic [CNT_W-1:0]  d, d_nxt;
  logic [LINE_W-1:0] rem, rem_nxt, rem_dec;
  logic [CNT_W-1:0]  vs_clamp;
  logic              data_pop, data_starve, tu_end;
  logic              uf_q, ov_q;

  // Data slots in a TU: min(V, symbols still owed at TU start).
  function automatic logic [CNT_W-1:0] dmin(input logic [CNT_W-1:0] v, input logic [LINE_W-1:0] r);
    return (r < LINE_W'(v)) ? r[CNT_W-1:0] : v;
  endfunction

  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot;
    v_s_nxt     = v_s;
    d_nxt       = d;
    rem_nxt     = rem;
    vs_clamp    = (bus.cfg_vld_symbols == '0)  ? CNT_W'(1) :
                  (bus.cfg_vld_symbols > TU_C) ? TU_C : bus.cfg_vld_symbols;
    data_pop    = (state == DATA) && !bus.fifo_empty;
    data_starve = (state == DATA) && bus.fifo_empty;
    rem_dec     = rem - LINE_W'(data_pop);
    tu_end      = (state != IDLE) && (slot == LAST);

    case (state)
      IDLE: if (bus.line_start && bus.cfg_en && bus.cfg_line_symbols != '0) begin
        state_nxt = DATA;
        slot_nxt  = '0;
        v_s_nxt   = vs_clamp;
        rem_nxt   = bus.cfg_line_symbols;
        d_nxt     = dmin(vs_clamp, bus.cfg_line_symbols);
      end
      DATA:  if (slot + CNT_W'(1) == d)
               state_nxt = (d == TU_C) ? DATA : (d == LAST) ? FE : FS;
      FS:    state_nxt = (slot + CNT_W'(1) == LAST) ? FE : STUFF;
      STUFF: if (slot + CNT_W'(1) == LAST) state_nxt = FE;
      default: ;
    endcase

    if (state != IDLE) begin
      rem_nxt  = rem_dec;
      slot_nxt = tu_end ? '0 : slot + CNT_W'(1);
      // Starved data slots leave rem untouched, so the line may need extra TUs.
      if (tu_end) begin
        if (rem_dec == '0) state_nxt = IDLE;
        else begin
          state_nxt = DATA;
          d_nxt     = dmin(v_s, rem_dec);
        end
      end
      if (!bus.cfg_en) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot  <= '0;
      v_s   <= '0;
      d     <= '0;
      rem   <= '0;
      uf_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      v_s   <= v_s_nxt;
      d     <= d_nxt;
      rem   <= rem_nxt;
      uf_q  <= uf_q | data_starve;
      ov_q  <= ov_q | (bus.line_start && state != IDLE);
    end
  end

  always_comb begin
    bus.sched_stream_en    = (state != IDLE);
    bus.sched_rd_en        = data_pop;
    bus.sched_line_done    = tu_end && (rem_dec == '0);
    bus.sched_underflow    = uf_q | data_starve;
    bus.sched_overrun      = ov_q;
    case (state)
      DATA:    bus.sched_stream_state = data_pop ? 2'b01 : 2'b00;
      FS:      bus.sched_stream_state = 2'b10;
      FE:      bus.sched_stream_state = 2'b11;
      default: bus.sched_stream_state = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_tu_stream_scheduler.sv
// Random and directed check of tu_stream_scheduler against a slot-arithmetic reference model.
module tb_tu_stream_scheduler;
  localparam int TU     = 64;
  localparam int CNT_W  = $clog2(TU) + 1;
  localparam int LINE_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   uf_exp = 1'b0;

  always #5 clk = ~clk;

  tu_stream_scheduler_if #(.CNT_W(CNT_W), .LINE_W(LINE_W)) bus ();

  tu_stream_scheduler #(.TU_SIZE(TU), .CNT_W(CNT_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] out_vec();
    return {bus.sched_stream_en, bus.sched_stream_state, bus.sched_rd_en,
            bus.sched_line_done, bus.sched_underflow};
  endfunction

  // mode 0: FIFO always full, 1: 3-slot starve burst, 2: random starve + cfg churn
  task automatic run_line(input int v, input int l, input int mode, input int exp_slots);
    int vc, rem, k, d, slots, pops;
    bit emp, done, ld;
    logic [1:0] code;
    vc = (v == 0) ? 1 : (v > TU ? TU : v);
    rem = l; k = 0; d = (vc < rem) ? vc : rem;
    slots = 0; pops = 0; done = 1'b0;
    @(negedge clk);
    bus.cfg_en = 1'b1;
    bus.cfg_vld_symbols = CNT_W'(v);
    bus.cfg_line_symbols = LINE_W'(l);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    while (!done && slots < 20000) begin
      case (mode)
        1:       emp = (slots >= 5 && slots < 8);
        2:       emp = ($urandom_range(0, 9) == 0);
        default: emp = 1'b0;
      endcase
      if (mode == 2 && slots == 3) begin
        bus.cfg_vld_symbols  = CNT_W'($urandom_range(0, 127));
        bus.cfg_line_symbols = LINE_W'($urandom_range(1, 500));
      end
      bus.fifo_empty = emp;
      #1;
      if (k < d) begin
        code = emp ? 2'b00 : 2'b01;
        if (!emp) rem--;
        uf_exp |= emp;
      end else if (k == TU - 1) code = 2'b11;
      else if (k == d)          code = 2'b10;
      else                      code = 2'b00;
      ld = (k == TU - 1) && (rem == 0);
      chk("slot", 32'(out_vec()), 32'({1'b1, code, (k < d) && !emp, ld, uf_exp}));
      pops += int'(bus.sched_rd_en);
      done = ld;
      k++;
      if (k == TU) begin
        k = 0;
        d = (vc < rem) ? vc : rem;
      end
      slots++;
      @(negedge clk);
    end
    if (!done) chk("line_timeout", 32'(slots), 32'(0));
    bus.fifo_empty = 1'b0;
    #1;
    chk("idle_after_line", 32'(bus.sched_stream_en), 32'(0));
    chk("rd_count", 32'(pops), 32'(l));
    if (exp_slots > 0) chk("slot_count", 32'(slots), 32'(exp_slots));
  endtask

  initial begin
    int ld_seen;
    bus.cfg_en = 1'b0;
    bus.cfg_vld_symbols = '0;
    bus.cfg_line_symbols = '0;
    bus.line_start = 1'b0;
    bus.fifo_empty = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({out_vec(), bus.sched_overrun}), 32'(0));
    rst = 1'b0;

    run_line(60, 120, 0, 128);
    run_line(63, 63, 0, 64);
    run_line(64, 128, 0, 128);
    run_line(10, 25, 0, 192);
    run_line(60, 120, 1, 192);
    chk("underflow_sticky", 32'(bus.sched_underflow), 32'(1));

    repeat (8) begin
      int v, vc;
      v  = $urandom_range(0, 127);
      vc = (v == 0) ? 1 : (v > TU ? TU : v);
      run_line(v, $urandom_range(1, vc * 3 + 2), 2, 0);
    end

    // zero-length line is ignored
    @(negedge clk);
    bus.cfg_line_symbols = '0;
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    chk("zero_line_ignored", 32'(bus.sched_stream_en), 32'(0));
    chk("no_overrun_idle", 32'(bus.sched_overrun), 32'(0));

    // overrun then abort via cfg_en
    bus.cfg_vld_symbols = CNT_W'(64);
    bus.cfg_line_symbols = LINE_W'(128);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    repeat (10) @(negedge clk);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    chk("overrun_set", 32'(bus.sched_overrun), 32'(1));
    chk("busy_before_abort", 32'(bus.sched_stream_en), 32'(1));
    bus.cfg_en = 1'b0;
    ld_seen = int'(bus.sched_line_done);
    @(negedge clk);
    ld_seen += int'(bus.sched_line_done);
    chk("abort_idle", 32'(bus.sched_stream_en), 32'(0));
    chk("abort_no_line_done", 32'(ld_seen), 32'(0));
    chk("overrun_sticky", 32'(bus.sched_overrun), 32'(1));

    // rst mid-line clears everything
    bus.cfg_en = 1'b1;
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    repeat (5) @(negedge clk);
    bus.fifo_empty = 1'b1;
    #1;
    chk("starve_slot", 32'({bus.sched_stream_state, bus.sched_rd_en}), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_midline", 32'({out_vec(), bus.sched_overrun}), 32'(0));
    rst = 1'b0;
    bus.fifo_empty = 1'b0;
    uf_exp = 1'b0;
    run_line(5, 7, 0, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
